// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port pixel RAM between VGA scan-out and the UI drawing
// engine. Frame pixels are prefetched in raster order into a small FIFO that
// feeds the VGA pixel path; RAM cycles not needed for prefetch go to the
// writer, and a wait counter forces a writer grant after MAX_WAIT held-off
// cycles.
//
// Ports
//   clk, rst              system clock, asynchronous active-high reset
//   frame_start           1-cycle pulse at start of frame; restarts prefetch
//   pix_rd                consume one pixel
//   pix_data              current pixel (registered, held until next pop)
//   underflow             sticky: pix_rd seen with FIFO empty this frame
//   wr_valid/wr_ready     writer handshake (wr_ready is combinational)
//   wr_addr/wr_data       writer address/data
//   mem_addr/mem_re/mem_we/mem_wdata   registered RAM strobes
//   mem_rdata             RAM read data, valid the cycle after mem_re
//
// state   | meaning
// S_IDLE  | no frame started yet; writer owns the RAM
// S_FETCH | prefetching pixels of the current frame
// S_DONE  | last pixel of the frame issued; writer owns the RAM
module vga_fb_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_WAIT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic              underflow,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(MAX_WAIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  occupancy;
  logic              rd_ret;
  logic [WAIT_W-1:0] wait_cnt;
  logic              fetch_need;
  logic              wr_go;
  logic              fetch_go;
  logic              push;
  logic              pop;

  // Reads in flight (mem_re now, rd_ret returning now) already own a FIFO
  // slot, so the FIFO can never overflow when their data lands.
  assign occupancy = fifo_cnt + CNT_W'(mem_re) + CNT_W'(rd_ret);

  // No fetch in the frame_start cycle: the fetch address is being reset.
  assign fetch_need = (state == S_FETCH) && (occupancy < DEPTH_C) && !frame_start;
  assign wr_ready   = !fetch_need || (wait_cnt == WAIT_MAX_C);
  assign wr_go      = wr_valid && wr_ready;
  assign fetch_go   = fetch_need && !wr_go;
  assign push       = rd_ret && !frame_start;
  assign pop        = pix_rd && !frame_start && (fifo_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      fetch_addr <= '0;
    end else if (frame_start) begin
      state      <= S_FETCH;
      fetch_addr <= '0;
    end else if (fetch_go) begin
      if (fetch_addr == LAST_ADDR) state <= S_DONE;
      else fetch_addr <= fetch_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_ret    <= 1'b0;
    end else begin
      mem_re <= fetch_go;
      mem_we <= wr_go;
      // A read already on the bus when frame_start hits returns stale data.
      rd_ret <= mem_re && !frame_start;
      if (wr_go) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (fetch_go) begin
        mem_addr <= fetch_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= '0;
    else if (wr_valid && !wr_ready) wait_cnt <= wait_cnt + 1'b1;
    else wait_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      pix_data  <= '0;
      underflow <= 1'b0;
    end else if (frame_start) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      pix_data  <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (pix_rd) begin
        if (fifo_cnt != '0) begin
          pix_data <= fifo_mem[rd_ptr];
        end else begin
          pix_data  <= '0;
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a reduced 16x4 frame (64 pixels).
// The RAM model returns addr[7:0] one cycle after mem_re.
module tb_vga_fb_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] W_ADDR = 19'h01234;
  localparam logic [DATA_W-1:0] W_DATA = 8'h3C;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic              pix_rd;
  logic [DATA_W-1:0] pix_data;
  logic              underflow;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  int total = 0;
  int bad = 0;
  int exp_fa = 0;
  int nreads = 0;
  int run = 0;
  int max_run = 0;

  vga_fb_arbiter #(
    .H_ACTIVE(16), .V_ACTIVE(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .FIFO_DEPTH(8), .MAX_WAIT(15)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_rd(pix_rd),
    .pix_data(pix_data), .underflow(underflow), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_re) mem_rdata <= mem_addr[7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after an edge, track writer wait,
  // then sample just after the next edge. exp_pix < 0 means no pixel check.
  task automatic cycle(input logic do_pop, input logic do_wr, input logic do_fs,
                       input int exp_pix);
    pix_rd = do_pop;
    wr_valid = do_wr;
    frame_start = do_fs;
    if (do_fs) begin
      exp_fa = 0;
      nreads = 0;
    end
    #1;
    if (do_wr && !wr_ready) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    @(posedge clk);
    #1;
    pix_rd = 1'b0;
    wr_valid = 1'b0;
    frame_start = 1'b0;
    chk("re_we_excl", 32'(mem_re & mem_we), 32'd0);
    if (mem_re) begin
      chk("fetch_addr", 32'(mem_addr), 32'(exp_fa));
      exp_fa++;
      nreads++;
    end
    if (mem_we) begin
      chk("wr_mem_addr", 32'(mem_addr), 32'(W_ADDR));
      chk("wr_mem_data", 32'(mem_wdata), 32'(W_DATA));
    end
    if (exp_pix >= 0) chk("pix_data", 32'(pix_data), 32'(exp_pix));
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    pix_rd = 1'b0;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    rst = 1'b0;

    // idle writer access
    wr_valid = 1'b1;
    wr_addr = 19'd5;
    wr_data = 8'hA5;
    #1;
    chk("idle_wr_ready", 32'(wr_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("idle_mem_we", 32'(mem_we), 32'd1);
    chk("idle_mem_addr", 32'(mem_addr), 32'd5);
    chk("idle_mem_wdata", 32'(mem_wdata), 32'hA5);
    chk("idle_mem_re", 32'(mem_re), 32'd0);
    wr_valid = 1'b0;
    wr_addr = W_ADDR;
    wr_data = W_DATA;

    // frame start, no consumer: FIFO fills with exactly 8 reads
    cycle(1'b0, 1'b0, 1'b1, -1);
    repeat (20) cycle(1'b0, 1'b0, 1'b0, -1);
    chk("fill_nreads", 32'(nreads), 32'd8);
    chk("fill_mem_re", 32'(mem_re), 32'd0);

    // pop every cycle with writer held: fetch demand continuous, writer
    // must still be forced through after 15 held-off cycles
    max_run = 0;
    run = 0;
    for (int k = 0; k < 40; k++) cycle(1'b1, 1'b1, 1'b0, k);
    chk("busy_max_wait", 32'(max_run), 32'd15);
    chk("busy_underflow", 32'(underflow), 32'd0);

    // pop every 2nd cycle to the end of the frame
    for (int k = 40; k < 64; k++) begin
      cycle(1'b1, 1'b1, 1'b0, k);
      cycle(1'b0, 1'b1, 1'b0, -1);
    end
    repeat (6) cycle(1'b0, 1'b1, 1'b0, -1);
    chk("frame_nreads", 32'(nreads), 32'd64);
    chk("frame_mem_re", 32'(mem_re), 32'd0);
    chk("frame_underflow", 32'(underflow), 32'd0);
    chk("frame_wait_bound", 32'(max_run <= 15), 32'd1);
    wr_valid = 1'b1;
    #1;
    chk("done_wr_ready", 32'(wr_ready), 32'd1);
    wr_valid = 1'b0;

    // pop right after frame_start: FIFO empty
    cycle(1'b0, 1'b0, 1'b1, -1);
    chk("fs_pix_clear", 32'(pix_data), 32'd0);
    chk("fs_underflow_clear", 32'(underflow), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    chk("empty_pop_underflow", 32'(underflow), 32'd1);
    repeat (20) cycle(1'b0, 1'b0, 1'b0, -1);
    chk("underflow_sticky", 32'(underflow), 32'd1);
    chk("uf_nreads", 32'(nreads), 32'd8);
    cycle(1'b0, 1'b0, 1'b1, -1);
    chk("fs_clears_underflow", 32'(underflow), 32'd0);

    // restart with reads in flight
    repeat (20) cycle(1'b0, 1'b0, 1'b0, -1);
    chk("refill_nreads", 32'(nreads), 32'd8);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, k);
    chk("inflight_mem_re", 32'(mem_re), 32'd1);
    chk("inflight_addr", 32'(mem_addr), 32'd9);
    cycle(1'b0, 1'b0, 1'b1, -1);
    repeat (20) cycle(1'b0, 1'b0, 1'b0, -1);
    chk("restart_nreads", 32'(nreads), 32'd8);
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 1'b0, k);
    chk("restart_underflow", 32'(underflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
